// File: rtl/pipelined_rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry add/subtract unit.
package pipelined_rca_pkg;

  // Widest chunk a single pipeline stage may resolve.
  localparam int unsigned MaxChunkW = 64;

  typedef struct packed {
    logic [MaxChunkW-1:0] s;
    logic                 c;
  } chunk_res_t;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  function automatic chunk_res_t make_chunk_res(input logic [MaxChunkW-1:0] s,
                                                input logic                 c);
    chunk_res_t r;
    r.s = s;
    r.c = c;
    return r;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational Width-bit ripple-carry adder built from full-adder equations.
module rca_chunk #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             ci_i,
  output logic [Width-1:0] s_o,
  output logic             co_o
);

  logic c;

  always_comb begin
    c   = ci_i;
    s_o = '0;
    for (int i = 0; i < Width; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined WIDTH-bit ripple-carry add/subtract, one CW-bit chunk per stage.
// Define PIPELINED_RCA_OVF_EN to add the signed-overflow output ovf.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0 || CW > MaxChunkW) begin : g_bad_params
    $error("pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
  end

  logic                          adv;
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0]  b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0]  s_q, s_d;
  logic [STAGES-1:0]             c_q, c_d;
  chunk_res_t [STAGES-1:0]       res;
  logic [WIDTH-1:0]              b_cap;

  // Subtraction is a + ~b + 1; B is inverted once, at capture.
  assign b_cap = sub ? ~b : b;

  assign adv       = !valid_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

`ifdef PIPELINED_RCA_OVF_EN
  logic ovf_d, ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0]    ca, cb, cs;
    logic             ci, co;
    logic [WIDTH-1:0] s_prev, s_new;

    if (k == 0) begin : g_first
      assign ca         = a[CW-1:0];
      assign cb         = b_cap[CW-1:0];
      assign ci         = sub ? 1'b1 : cin;
      assign s_prev     = '0;
      assign a_d[k]     = a;
      assign b_d[k]     = b_cap;
      assign valid_d[k] = in_valid;
    end else begin : g_next
      assign ca         = a_q[k-1][k*CW +: CW];
      assign cb         = b_q[k-1][k*CW +: CW];
      assign ci         = c_q[k-1];
      assign s_prev     = s_q[k-1];
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end

    rca_chunk #(
      .Width(CW)
    ) u_chunk (
      .a_i (ca),
      .b_i (cb),
      .ci_i(ci),
      .s_o (cs),
      .co_o(co)
    );

    assign res[k] = make_chunk_res(MaxChunkW'(cs), co);

    // Lower chunks already resolved travel forward; this stage fills chunk k.
    always_comb begin
      s_new              = s_prev;
      s_new[k*CW +: CW]  = res[k].s[CW-1:0];
    end

    assign s_d[k] = s_new;
    assign c_d[k] = res[k].c;

`ifdef PIPELINED_RCA_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      // a ^ b' ^ s at the MSB recovers the carry into the MSB.
      assign ovf_d = ca[CW-1] ^ cb[CW-1] ^ cs[CW-1] ^ co;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

`ifdef PIPELINED_RCA_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // Consumed operand chunks and not-yet-resolved sum chunks have no readers.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, s_q, res};

endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
Parametrised, pipelined ripple-carry add/subtract unit. It is the next generation of the team's 4-bit combinational adder.
- The WIDTH-bit carry chain is split into STAGES equal chunks, one chunk resolved per pipeline stage, with the carry registered between stages.
- It accepts one operation per cycle under a valid/ready handshake.
- It sits as the arithmetic core ahead of the planned ALU/accumulator datapath.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth; 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  pipeline can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in (ignored when sub=1)
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  output  1  result presented
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; in subtract mode 1 = no borrow

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: all stage valid bits 0, all data/carry registers 0. Therefore out_valid=0, sum=0, cout=0, and in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded, with no partial result emitted.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Advance condition: advance = !out_valid | out_ready, with in_ready = advance.
  - The whole pipeline moves one stage when advance=1 and holds all registers when advance=0.
  - Bubbles (stage valid=0) propagate like data.
- Stage k (0..STAGES-1): adds chunk k of A and B' plus the carry from stage k-1. Stage 0 carry-in = sub ? 1 : cin.
  - B' = sub ? ~b : b, inverted at capture.
  - Upper operand chunks travel as delayed copies; already-computed lower sum chunks are carried forward alongside.
- Latency: exactly STAGES cycles from input transfer to out_valid, when there is no back-pressure. Throughput is 1 op/cycle.
- sum/cout are stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - cout = bit WIDTH of the full-width result.
  - Results are identical to a single-cycle WIDTH-bit ripple adder for all inputs.
- STAGES=1 gives a single registered adder with latency 1.
- a, b, cin and sub are don't-care when in_valid=0; such cycles insert a bubble.
- Elaboration error if WIDTH % STAGES != 0 or STAGES<1.

Optional Feature:
PIPELINED_RCA_OVF_EN
- When defined:
  - Adds output port ovf (1 bit) = two's-complement signed overflow of the operation.
  - ovf = carry into MSB XOR carry out of MSB.
  - ovf travels with sum, is reset to 0, and is held under back-pressure.
- When undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package pipelined_rca_pkg: localparam helper for CW, and a chunk-result struct {logic [CW-1:0] s; logic c;} built via a parameterised function.
- Sub-module rca_chunk: combinational CW-bit ripple adder (a, b, ci -> s, co) built from bit-level full-adder equations. It is instantiated once per stage in a generate loop.
- The top level holds the stage registers, skew/deskew registers and handshake logic.

Test Plan (WIDTH=16, STAGES=4 unless stated):
1. Carry across every stage boundary: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1.
2. Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
3. Throughput: 8 back-to-back ops, out_ready=1 -> results appear on 8 consecutive cycles in order, starting 4 cycles after the first input. Check against a reference model for 10k random ops, including STAGES=1 and STAGES=16 builds.
4. Back-pressure: hold out_ready=0 for 5 cycles while streaming -> in_ready=0, sum/cout/out_valid stable. Nothing is lost or duplicated after release.
5. Reset mid-flight: assert rst with 3 ops in flight -> next cycle out_valid=0, sum=0. Those 3 ops are never emitted.
6. With PIPELINED_RCA_OVF_EN:
   - a=0x7FFF + b=0x0001 -> ovf=1, sum=0x8000.
   - a=0x8000 - b=0x0001 -> ovf=1.
   - 0x0003+0x0004 -> ovf=0.
